// File: rtl/imem_bridge_pkg.sv
// Shared types and constants for the instruction-memory bridge.
package imem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } imem_state_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_bridge_if.sv
// Ready/valid request/response bus between the fetch bridge and the i-mem interconnect.
interface imem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/imem_bridge_timeout.sv
// imem_timeout: saturating cycle counter with synchronous clear, enable and a hit flag
// at MAX. Used by imem_bridge only when IMEM_FAULT_EN is defined.
module imem_timeout #(
   parameter int MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);
   localparam int TMO_W = $clog2(MAX + 1);

   logic [TMO_W-1:0] cnt_r;

   // Count enabled cycles, holding at MAX; clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (en && (cnt_r != TMO_W'(MAX))) begin
         cnt_r <= cnt_r + TMO_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign hit = (cnt_r == TMO_W'(MAX));
endmodule

// File: rtl/imem_bridge.sv
// Instruction-memory bridge: one ready/valid fetch in flight, registered result for PC_e.
// Optional IMEM_FAULT_EN adds response-error and timeout faults.
module imem_bridge
   import imem_bridge_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR      = DATA_W'(NOP_INSTR_DEFAULT),
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_f,
   output logic              fetch_stall,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   imem_bridge_if.master     bus
);
   imem_state_t       state_r;
   imem_state_t       next_s;
   logic [ADDR_W-1:0] addr_r;
   logic              req_valid_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic              stall_s;
   logic              take_s;
   logic              fault_s;
   logic              err_s;
   logic              tmo_hit_s;

`ifdef IMEM_FAULT_EN
   assign err_s = bus.rsp_err;

   imem_timeout #(
      .MAX (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr ((state_r != RESP) && (next_s == RESP)),
      .en  (state_r == RESP),
      .hit (tmo_hit_s)
   );
`else
   logic unused_s;
   assign err_s     = 1'b0;
   assign tmo_hit_s = 1'b0;
   assign unused_s  = bus.rsp_err ^ (TIMEOUT_CYCLES == 0);
`endif

   // Next-state and bus/stall decode; a response beats a simultaneous timeout.
   always_comb begin
      next_s      = state_r;
      req_valid_s = 1'b0;
      req_addr_s  = addr_r;
      stall_s     = 1'b1;
      take_s      = 1'b0;
      fault_s     = 1'b0;
      case (state_r)
         IDLE: begin
            req_valid_s = 1'b1;
            req_addr_s  = pc_f;
            if (bus.req_ready) next_s = RESP;
            else               next_s = REQ;
         end
         REQ: begin
            req_valid_s = 1'b1;
            if (bus.req_ready) next_s = RESP;
            else               next_s = REQ;
         end
         RESP: begin
            if (bus.rsp_valid) begin
               stall_s = 1'b0;
               take_s  = 1'b1;
               fault_s = err_s;
               next_s  = IDLE;
            end else if (tmo_hit_s) begin
               stall_s = 1'b0;
               take_s  = 1'b1;
               fault_s = 1'b1;
               next_s  = IDLE;
            end else begin
               next_s = RESP;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   assign bus.req_valid = req_valid_s & ~rst;
   assign bus.req_addr  = req_addr_s;
   assign fetch_stall   = stall_s | rst;

   // State register and address capture; the address tracks pc_f only while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         addr_r  <= {ADDR_W{1'b0}};
      end else begin
         state_r <= next_s;
         addr_r  <= (state_r == IDLE) ? pc_f : addr_r;
      end
   end

   // Instruction register, valid pulse and fault reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         fault_addr  <= {ADDR_W{1'b0}};
      end else begin
         instr       <= take_s ? (fault_s ? NOP_INSTR : bus.rsp_data) : instr;
         instr_valid <= take_s;
         fault       <= fault_s;
         fault_addr  <= fault_s ? addr_r : fault_addr;
      end
   end
endmodule
